prog_mem_loader: RTL and testbench

- Program memory that answers the controller's instruction-fetch port. It returns memdata for memaddr combinationally, so a word driven in fetch state 0 is captured on that same edge.
- Filled at boot from a byte stream (UART/host side) using a framed, checksummed protocol.
- Holds the controller in reset, via cpu_reset, until a frame loads successfully.

---
 rtl/prog_mem_loader.sv | 161 ++++++++++++++++
 tb/tb_prog_mem_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Boot-time program memory: asynchronous instruction-fetch read port, filled from a
// framed, XOR-checksummed byte stream; holds the controller in reset until a frame loads.
module prog_mem_loader #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] memaddr,
  output logic [31:0] memdata,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        cpu_reset,
  output logic        loaded,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t                 state_r;
  logic [31:0]            mem_r [DEPTH];
  logic [15:0]            len_r;
  logic [1:0]             byte_cnt_r;
  logic [ADDR_BITS-1:0]   wr_addr_r;
  logic [7:0]             csum_r;
  logic [23:0]            shift_r;

  logic                   accept_s;
  logic                   wr_en_s;
  logic [31:0]            wr_word_s;
  logic [15:0]            len_s;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Handshake qualification and assembly of the word completed by the current byte
  always_comb begin
    accept_s  = rx_valid && rx_ready;
    wr_en_s   = accept_s && (state_r == DATA) && (byte_cnt_r == 2'd3) && !reset;
    wr_word_s = {shift_r, rx_data};
    len_s     = {len_r[15:8], rx_data};
  end

  // Fetch port: out-of-range addresses read as zero
  always_comb begin
    memdata = 32'd0;
    if ({16'd0, memaddr} < 32'(DEPTH)) begin
      memdata = mem_r[memaddr[ADDR_BITS-1:0]];
    end else begin
      memdata = 32'd0;
    end
  end

  // Memory array write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_r] <= wr_word_s;
    end
  end

  // Frame receive state machine with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cpu_reset    <= 1'b1;
      loaded       <= 1'b0;
      load_error   <= 1'b0;
      rx_ready     <= 1'b0;
      words_loaded <= 16'd0;
      len_r        <= 16'd0;
      byte_cnt_r   <= 2'd0;
      wr_addr_r    <= '0;
      csum_r       <= 8'd0;
      shift_r      <= 24'd0;
    end else begin
      case (state_r)
        IDLE, DONE, ERR: begin
          if (load_start) begin
            state_r      <= LEN_HI;
            rx_ready     <= 1'b1;
            cpu_reset    <= 1'b1;
            loaded       <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= 16'd0;
            wr_addr_r    <= '0;
            csum_r       <= 8'd0;
            byte_cnt_r   <= 2'd0;
          end
        end
        LEN_HI: begin
          if (accept_s) begin
            len_r[15:8] <= rx_data;
            csum_r      <= csum_next(csum_r, rx_data);
            state_r     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept_s) begin
            len_r[7:0] <= rx_data;
            csum_r     <= csum_next(csum_r, rx_data);
            if (32'(len_s) > 32'(DEPTH)) begin
              state_r    <= ERR;
              rx_ready   <= 1'b0;
              load_error <= 1'b1;
            end else if (len_s == 16'd0) begin
              state_r <= CSUM;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
            csum_r     <= csum_next(csum_r, rx_data);
            shift_r    <= {shift_r[15:0], rx_data};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              // wr_addr may wrap after the top-address write; CSUM follows immediately
              wr_addr_r    <= wr_addr_r + ADDR_BITS'(1);
              words_loaded <= words_loaded + 16'd1;
              if ((words_loaded + 16'd1) == len_r) begin
                state_r <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (accept_s) begin
            rx_ready <= 1'b0;
            if (rx_data == csum_r) begin
              state_r   <= DONE;
              loaded    <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state_r    <= ERR;
              load_error <= 1'b1;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: stimulus queues expected frame outcomes and
// memory reads; a negedge monitor pops and compares when the DUT presents them.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        reset, load_start, rx_valid;
  logic        rx_ready, cpu_reset, loaded, load_error;
  logic [15:0] memaddr, words_loaded;
  logic [31:0] memdata;
  logic [7:0]  rx_data;

  typedef struct packed {
    logic        ld;
    logic        er;
    logic        cr;
    logic        rr;
    logic [15:0] wl;
  } outc_t;

  outc_t       out_q[$];
  string       out_name_q[$];
  logic [31:0] rd_q[$];
  logic [15:0] rd_addr_q[$];

  int   vectors     = 0;
  int   miscompares = 0;
  logic probe       = 1'b0;
  logic rd          = 1'b0;
  logic prev_term   = 1'b0;
  logic last_acc    = 1'b0;

  prog_mem_loader #(.ADDR_BITS(10)) dut (
    .clk(clk), .reset(reset), .memaddr(memaddr), .memdata(memdata),
    .load_start(load_start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .cpu_reset(cpu_reset), .loaded(loaded),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_acc <= rx_valid && rx_ready;

  // Monitor: frame outcomes on terminal-flag rise or probe, reads on rd strobe
  always @(negedge clk) begin : monitor
    logic        term;
    outc_t       e, a;
    string       n;
    logic [31:0] ed;
    logic [15:0] ea;
    term = loaded | load_error;
    if ((term && !prev_term) || probe) begin
      vectors++;
      if (out_q.size() == 0) begin
        miscompares++;
        $display("FAIL outcome: unexpected status event ld=%0b err=%0b", loaded, load_error);
      end else begin
        e = out_q.pop_front();
        n = out_name_q.pop_front();
        a = {loaded, load_error, cpu_reset, rx_ready, words_loaded};
        if (a !== e) begin
          miscompares++;
          $display("FAIL %s: got ld=%0b err=%0b cpu_rst=%0b rdy=%0b words=%0d, want ld=%0b err=%0b cpu_rst=%0b rdy=%0b words=%0d",
                   n, a.ld, a.er, a.cr, a.rr, a.wl, e.ld, e.er, e.cr, e.rr, e.wl);
        end else if (!probe && !last_acc) begin
          miscompares++;
          $display("FAIL %s: status got late edge, want edge right after final accepted byte", n);
        end
      end
    end
    prev_term = term;
    if (rd) begin
      vectors++;
      ed = rd_q.pop_front();
      ea = rd_addr_q.pop_front();
      if (memdata !== ed) begin
        miscompares++;
        $display("FAIL read[%h]: got %h, want %h", ea, memdata, ed);
      end
    end
  end

  task automatic expect_out(input string n, input logic ld, input logic er,
                            input logic cr, input logic rr, input logic [15:0] wl);
    out_q.push_back({ld, er, cr, rr, wl});
    out_name_q.push_back(n);
  endtask

  task automatic do_probe(input string n, input logic ld, input logic er,
                          input logic cr, input logic rr, input logic [15:0] wl);
    expect_out(n, ld, er, cr, rr, wl);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic expect_rd(input logic [15:0] a, input logic [31:0] d);
    memaddr = a;
    rd_q.push_back(d);
    rd_addr_q.push_back(a);
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waitc;
    waitc    = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!rx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept: rx_ready got 0 for 50 cycles, want 1 for byte %h", b);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int gap);
    foreach (fr[i]) send_byte(fr[i], gap);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (out_q.size() != 0 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    while (out_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no status event, want one within 20 cycles", out_name_q.pop_front());
      void'(out_q.pop_front());
    end
  endtask

  initial begin
    logic [7:0]  fr[$];
    logic [7:0]  cs;
    logic [31:0] w;
    reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; memaddr = 16'h0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    do_probe("reset_state", 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);

    // good 2-word frame, continuous stream
    expect_out("good_frame", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    pulse_start();
    fr = '{8'h00, 8'h02, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFA};
    send_frame(fr, 0);
    wait_drain();
    expect_rd(16'h0000, 32'hF000_0000);
    expect_rd(16'h0001, 32'h1234_5678);
    expect_rd(16'h0400, 32'h0000_0000);

    // same frame with a wrong checksum
    expect_out("bad_csum", 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    pulse_start();
    fr[10] = 8'h00;
    send_frame(fr, 0);
    wait_drain();
    expect_rd(16'h0001, 32'h1234_5678);

    // length 0x0401 exceeds depth
    expect_out("len_overflow", 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    pulse_start();
    fr = '{8'h04, 8'h01};
    send_frame(fr, 0);
    wait_drain();
    expect_rd(16'h0000, 32'hF000_0000);
    expect_rd(16'h0001, 32'h1234_5678);

    // full-depth frame: N = 1024, last word lands on the top address
    expect_out("full_depth", 1'b1, 1'b0, 1'b0, 1'b0, 16'd1024);
    pulse_start();
    fr = '{8'h04, 8'h00};
    cs = 8'h04;
    for (int i = 0; i < 1024; i++) begin
      w = {i[15:0], ~i[15:0]};
      for (int k = 3; k >= 0; k--) begin
        fr.push_back(w[k*8 +: 8]);
        cs = cs ^ w[k*8 +: 8];
      end
    end
    fr.push_back(cs);
    send_frame(fr, 0);
    wait_drain();
    expect_rd(16'h0000, 32'h0000_FFFF);
    expect_rd(16'h0001, 32'h0001_FFFE);
    expect_rd(16'h03FF, 32'h03FF_FC00);
    expect_rd(16'hFFFF, 32'h0000_0000);

    // zero-length frame leaves memory alone
    expect_out("zero_len", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    pulse_start();
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame(fr, 0);
    wait_drain();
    expect_rd(16'h0000, 32'h0000_FFFF);

    // reset in the middle of DATA, then a fresh 1-word frame
    pulse_start();
    fr = '{8'h00, 8'h02, 8'hF0, 8'h00, 8'h00};
    send_frame(fr, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    do_probe("mid_reset", 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    expect_rd(16'h0000, 32'h0000_FFFF);
    expect_out("after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    pulse_start();
    fr = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    send_frame(fr, 0);
    wait_drain();
    expect_rd(16'h0000, 32'hDEAD_BEEF);
    expect_rd(16'h0001, 32'h0001_FFFE);

    // gapped stream with a stray load_start during DATA
    expect_out("gapped", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    pulse_start();
    fr = '{8'h00, 8'h02, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFA};
    foreach (fr[i]) begin
      send_byte(fr[i], 3);
      if (i == 4) pulse_start();
    end
    wait_drain();
    expect_rd(16'h0000, 32'hF000_0000);
    expect_rd(16'h0001, 32'h1234_5678);

    // reset and load_start together: reset wins
    reset = 1'b1;
    load_start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    load_start = 1'b0;
    do_probe("reset_vs_start", 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);

    repeat (5) @(posedge clk);
    #1;
    if (out_q.size() != 0 || rd_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover: got %0d outcomes and %0d reads pending, want 0", out_q.size(), rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
